// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the block copier.
// MEMMOVE_EN (optional define) selects overlap-aware descending copies in mem_block_copier.
package mem_copy_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned LEN_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        COPY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Walk direction through the source/destination windows.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/mem_block_copier_if.sv
// Control handshake plus main_memory read/write port bundle for the block copier.
interface mem_block_copier_if #(
    parameter int unsigned ADDR_WIDTH = mem_copy_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = mem_copy_pkg::DATA_WIDTH,
    parameter int unsigned LEN_WIDTH  = mem_copy_pkg::LEN_WIDTH
);

    logic                  start;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [LEN_WIDTH-1:0]  length;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_write_ctrl;
    logic [DATA_WIDTH-1:0] mem_read_out;

    // Copier side: takes requests, drives the memory ports.
    modport master (
        input  start,
        input  src_addr,
        input  dst_addr,
        input  length,
        input  mem_read_out,
        output busy,
        output done,
        output mem_read_addr,
        output mem_write_addr,
        output mem_write_data,
        output mem_write_ctrl
    );

    // Environment side: control logic plus the attached memory.
    modport slave (
        output start,
        output src_addr,
        output dst_addr,
        output length,
        output mem_read_out,
        input  busy,
        input  done,
        input  mem_read_addr,
        input  mem_write_addr,
        input  mem_write_data,
        input  mem_write_ctrl
    );

endinterface

// File: rtl/mem_block_copier.sv
// DMA-style block copier driving a main_memory with 1-cycle registered reads.
// One word per cycle: PRIME issues the first read, each COPY cycle writes the
// word read in the previous cycle while issuing the next read.
// Optional define MEMMOVE_EN: overlapping forward copies run descending so the
// destination receives the original source data.
module mem_block_copier #(
    parameter int unsigned ADDR_WIDTH = mem_copy_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = mem_copy_pkg::DATA_WIDTH,
    parameter int unsigned LEN_WIDTH  = mem_copy_pkg::LEN_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    mem_block_copier_if.master bus
);

    import mem_copy_pkg::*;

    // One extra bit so a full 2^LEN_WIDTH-1 transfer compares cleanly.
    localparam int unsigned CNT_WIDTH = LEN_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr_next_c;
    logic [ADDR_WIDTH-1:0] wr_addr_next_c;
    logic [ADDR_WIDTH-1:0] rd_addr_start_c;
    logic [ADDR_WIDTH-1:0] wr_addr_start_c;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  count;
    logic                  busy_q;
    logic                  done_q;
    logic                  wr_en_q;
    logic                  accept_c;
    logic                  last_c;

    assign accept_c = (state == IDLE) && bus.start;
    assign last_c   = (state == COPY) && (count == len_q);

`ifdef MEMMOVE_EN
    localparam int unsigned CMP_WIDTH =
        ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;

    logic [ADDR_WIDTH-1:0] gap_c;
    logic [ADDR_WIDTH-1:0] span_c;
    logic                  overlap_c;
    dir_t                  dir_c;
    dir_t                  dir_q;

    // Destination starts inside the source window (modulo address space).
    assign gap_c     = bus.dst_addr - bus.src_addr;
    assign overlap_c = (gap_c != '0) && (CMP_WIDTH'(gap_c) < CMP_WIDTH'(bus.length));
    assign dir_c     = overlap_c ? DIR_DOWN : DIR_UP;
    assign span_c    = ADDR_WIDTH'(bus.length) - ADDR_ONE;

    // Descending copies start at the top word of each window.
    assign rd_addr_start_c = (dir_c == DIR_DOWN) ? bus.src_addr + span_c : bus.src_addr;
    assign wr_addr_start_c = (dir_c == DIR_DOWN) ? bus.dst_addr + span_c : bus.dst_addr;
    assign rd_addr_next_c  = (dir_q == DIR_DOWN) ? rd_addr - ADDR_ONE : rd_addr + ADDR_ONE;
    assign wr_addr_next_c  = (dir_q == DIR_DOWN) ? wr_addr - ADDR_ONE : wr_addr + ADDR_ONE;

    // Direction is fixed for the whole transfer when the request is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dir_q <= DIR_UP;
        end else if (accept_c) begin
            dir_q <= dir_c;
        end
    end
`else
    assign rd_addr_start_c = bus.src_addr;
    assign wr_addr_start_c = bus.dst_addr;
    assign rd_addr_next_c  = rd_addr + ADDR_ONE;
    assign wr_addr_next_c  = wr_addr + ADDR_ONE;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.length != '0) ? PRIME : DONE;
                end
            end
            PRIME: begin
                state_next = COPY;
            end
            COPY: begin
                if (last_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status and write strobe registered from the upcoming state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            busy_q  <= (state_next == PRIME) || (state_next == COPY);
            done_q  <= (state_next == DONE);
            wr_en_q <= (state_next == COPY);
        end
    end

    // Address and word-count pipeline; read address runs one word ahead of write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_addr <= '0;
            wr_addr <= '0;
            len_q   <= '0;
            count   <= '0;
        end else if (accept_c) begin
            rd_addr <= rd_addr_start_c;
            wr_addr <= wr_addr_start_c;
            len_q   <= {1'b0, bus.length};
            count   <= CNT_ONE;
        end else if (state == PRIME) begin
            rd_addr <= rd_addr_next_c;
        end else if (state == COPY) begin
            rd_addr <= rd_addr_next_c;
            wr_addr <= wr_addr_next_c;
            count   <= count + CNT_ONE;
        end
    end

    // Memory-port and status drive; write data passes straight from read_out.
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.mem_read_addr  = rd_addr;
    assign bus.mem_write_addr = wr_addr;
    assign bus.mem_write_ctrl = wr_en_q;
    assign bus.mem_write_data = bus.mem_read_out;

endmodule

// File: tb/tb_mem_block_copier.sv
// Directed bench for mem_block_copier against an inline write-first memory
// (ADDR_WIDTH = 8). Expected overlap/wrap results follow MEMMOVE_EN.
module tb_mem_block_copier;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned LW = 16;

    localparam logic [15:0] WA = 16'hA0A0;
    localparam logic [15:0] WB = 16'hB1B1;
    localparam logic [15:0] WC = 16'hC2C2;
    localparam logic [15:0] WD = 16'hD3D3;

    logic clock;
    logic reset;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:255];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    mem_block_copier_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    mem_block_copier #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write-first memory with 1-cycle registered read; ld_* is a bench backdoor.
    always @(posedge clock) begin
        if (bus.mem_write_ctrl) begin
            mem[bus.mem_write_addr] <= bus.mem_write_data;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (bus.mem_write_ctrl && (bus.mem_write_addr == bus.mem_read_addr)) begin
            bus.mem_read_out <= bus.mem_write_data;
        end else begin
            bus.mem_read_out <= mem[bus.mem_read_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clock);
        #1 ld_en = 1'b0;
    endtask

    task automatic load_abcd(input logic [AW-1:0] base);
        load(base,                 WA);
        load(AW'(base + 8'd1),     WB);
        load(AW'(base + 8'd2),     WC);
        load(AW'(base + 8'd3),     WD);
    endtask

    // Presents a request at a negedge; returns just after the accepting edge.
    task automatic kick(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
        @(negedge clock);
        bus.start    = 1'b1;
        bus.src_addr = s;
        bus.dst_addr = d;
        bus.length   = n;
        @(posedge clock);
        #1 bus.start = 1'b0;
    endtask

    // Samples ncyc cycles after the start edge; optionally pulses start at cycle poke_at.
    task automatic watch(input int ncyc, input int poke_at,
                         output int done_at, output int busy_n,
                         output int writes, output int pulses);
        done_at = -1;
        busy_n  = 0;
        writes  = 0;
        pulses  = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clock);
            if (bus.busy) busy_n++;
            if (bus.mem_write_ctrl) writes++;
            if (bus.done) begin
                pulses++;
                if (done_at < 0) done_at = k;
            end
            if (k == poke_at) begin
                bus.start    = 1'b1;
                bus.src_addr = 8'h30;
                bus.dst_addr = 8'h90;
                bus.length   = 16'd2;
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    int done_at, busy_n, writes, pulses;
    logic [15:0] exp_w [0:3];

    initial begin
        reset        = 1'b1;
        ld_en        = 1'b0;
        ld_addr      = '0;
        ld_data      = '0;
        bus.start    = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.length   = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy",  32'(bus.busy),           32'd0);
        check("rst_done",  32'(bus.done),           32'd0);
        check("rst_wctrl", 32'(bus.mem_write_ctrl), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_raddr", 32'(bus.mem_read_addr),  32'd0);
        check("rst_waddr", 32'(bus.mem_write_addr), 32'd0);

        // Basic 4-word copy.
        load_abcd(8'h10);
        kick(8'h10, 8'h40, 16'd4);
        watch(12, 0, done_at, busy_n, writes, pulses);
        check("basic_done_at", 32'(done_at), 32'd6);
        check("basic_busy_n",  32'(busy_n),  32'd5);
        check("basic_writes",  32'(writes),  32'd4);
        check("basic_pulses",  32'(pulses),  32'd1);
        check("basic_m40", 32'(mem[8'h40]), 32'(WA));
        check("basic_m41", 32'(mem[8'h41]), 32'(WB));
        check("basic_m42", 32'(mem[8'h42]), 32'(WC));
        check("basic_m43", 32'(mem[8'h43]), 32'(WD));

        // Zero length.
        kick(8'h10, 8'h40, 16'd0);
        watch(6, 0, done_at, busy_n, writes, pulses);
        check("zero_done_at", 32'(done_at), 32'd1);
        check("zero_busy_n",  32'(busy_n),  32'd0);
        check("zero_writes",  32'(writes),  32'd0);
        check("zero_pulses",  32'(pulses),  32'd1);

        // Forward overlap by one word.
        load_abcd(8'h10);
        kick(8'h10, 8'h11, 16'd3);
        watch(10, 0, done_at, busy_n, writes, pulses);
`ifdef MEMMOVE_EN
        exp_w[0] = WA; exp_w[1] = WB; exp_w[2] = WC;
`else
        exp_w[0] = WA; exp_w[1] = WA; exp_w[2] = WA;
`endif
        check("ovl_done_at", 32'(done_at), 32'd5);
        check("ovl_m10", 32'(mem[8'h10]), 32'(WA));
        check("ovl_m11", 32'(mem[8'h11]), 32'(exp_w[0]));
        check("ovl_m12", 32'(mem[8'h12]), 32'(exp_w[1]));
        check("ovl_m13", 32'(mem[8'h13]), 32'(exp_w[2]));

        // Address wrap across 0xFF -> 0x00 with the destination overlapping the source.
        load(8'hFE, 16'h0E0E);
        load(8'hFF, 16'h0F0F);
        load(8'h00, 16'h1010);
        load(8'h01, 16'h1111);
        kick(8'hFE, 8'h00, 16'd4);
        watch(12, 0, done_at, busy_n, writes, pulses);
`ifdef MEMMOVE_EN
        exp_w[0] = 16'h0E0E; exp_w[1] = 16'h0F0F; exp_w[2] = 16'h1010; exp_w[3] = 16'h1111;
`else
        exp_w[0] = 16'h0E0E; exp_w[1] = 16'h0F0F; exp_w[2] = 16'h0E0E; exp_w[3] = 16'h0F0F;
`endif
        check("wrap_done_at", 32'(done_at), 32'd6);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_m%0d", i), 32'(mem[i]), 32'(exp_w[i]));
        end

        // Reset during COPY cycle j=2 of an 8-word transfer.
        for (int i = 0; i < 8; i++) begin
            load(AW'(8'h20 + i), 16'(16'h2000 + i));
            load(AW'(8'h60 + i), 16'h0000);
        end
        kick(8'h20, 8'h60, 16'd8);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("mid_busy",  32'(bus.busy),           32'd0);
        check("mid_done",  32'(bus.done),           32'd0);
        check("mid_wctrl", 32'(bus.mem_write_ctrl), 32'd0);
        check("mid_raddr", 32'(bus.mem_read_addr),  32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("mid_m60", 32'(mem[8'h60]), 32'h2000);
        check("mid_m61", 32'(mem[8'h61]), 32'h0000);
        kick(8'h20, 8'h60, 16'd8);
        watch(15, 0, done_at, busy_n, writes, pulses);
        check("re_done_at", 32'(done_at), 32'd10);
        check("re_writes",  32'(writes),  32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("re_m6%0d", i), 32'(mem[8'h60 + i]), 32'(16'h2000 + i));
        end

        // start pulsed while busy must be ignored.
        load_abcd(8'h10);
        load(8'h90, 16'h5555);
        kick(8'h10, 8'h80, 16'd4);
        watch(20, 2, done_at, busy_n, writes, pulses);
        check("ign_done_at", 32'(done_at), 32'd6);
        check("ign_pulses",  32'(pulses),  32'd1);
        check("ign_writes",  32'(writes),  32'd4);
        check("ign_m80", 32'(mem[8'h80]), 32'(WA));
        check("ign_m83", 32'(mem[8'h83]), 32'(WD));
        check("ign_m90", 32'(mem[8'h90]), 32'h5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
